// File: rtl/fm_add_p2s_arb.sv
`default_nettype none
// ============================================================================
// Module   : fm_add_p2s_arb
// Brief    : Round-robin arbiter that shares one parallel-to-serial serializer
//            among NUM_REQ fm-add requesters, tags bursts and checks framing.
// Revision : 1.0
// ============================================================================
module fm_add_p2s_arb #(
    parameter  int NUM_REQ        = 4,
    parameter  int SEQ_CNT        = 5,
    parameter  int APP_DATA_WIDTH = 64,
    localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int PAR_W          = SEQ_CNT * APP_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PAR_W-1:0] par_in,
    output logic [NUM_REQ-1:0]       ack,
    input  logic                     dst_ready,
    output logic                     p2s_par_en,
    output logic [PAR_W-1:0]         p2s_par,
    input  logic                     p2s_seq_valid,
    input  logic                     p2s_seq_last,
    output logic [IDW-1:0]           burst_id,
    output logic                     busy,
    output logic [15:0]              burst_done_cnt,
    output logic                     frame_err
);

    localparam int            c_cnt_w = $clog2(SEQ_CNT);
    localparam int            c_out_w = $clog2(SEQ_CNT + 1) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SEQ_CNT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [IDW-1:0]       r_rr;
    logic [IDW-1:0]       r_cur_id;
    logic                 r_exp_last;
    logic [c_out_w-1:0]   r_out;

    logic                 w_gnt_vld;
    logic [IDW-1:0]       w_gnt_id;
    logic [IDW:0]         w_sum;
    logic [IDW-1:0]       w_rr_next;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic [PAR_W-1:0]     w_slice;
    logic                 w_can_load;
    logic                 w_seq_end;

    // Scan downward so the requester closest to the pointer is written last and wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            if (req[w_sum[IDW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_sum[IDW-1:0];
            end
        end
    end

    assign w_rr_next    = (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    assign w_gnt_onehot = NUM_REQ'(1) << w_gnt_id;
    assign w_slice      = par_in[w_gnt_id*PAR_W +: PAR_W];
    assign w_can_load   = w_gnt_vld && dst_ready;
    assign w_seq_end    = p2s_seq_valid && p2s_seq_last;

    assign busy = (r_state == S_LOAD) || (r_out != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_rr           <= '0;
            r_cur_id       <= '0;
            r_exp_last     <= 1'b0;
            r_out          <= '0;
            ack            <= '0;
            p2s_par_en     <= 1'b0;
            p2s_par        <= '0;
            burst_id       <= '0;
            burst_done_cnt <= '0;
            frame_err      <= 1'b0;
        end else begin
            ack        <= '0;
            r_exp_last <= p2s_par_en && (r_cnt == c_last);

            case (r_state)
                S_IDLE: begin
                    if (w_can_load) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= '0;
                        r_rr       <= w_rr_next;
                        r_cur_id   <= w_gnt_id;
                        ack        <= w_gnt_onehot;
                        p2s_par_en <= 1'b1;
                        p2s_par    <= w_slice;
                    end
                end
                S_LOAD: begin
                    if (r_cnt != c_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_can_load) begin
                        // Back-to-back reload keeps the load enable continuous.
                        r_cnt      <= '0;
                        r_rr       <= w_rr_next;
                        r_cur_id   <= w_gnt_id;
                        ack        <= w_gnt_onehot;
                        p2s_par    <= w_slice;
                    end else begin
                        r_state    <= S_IDLE;
                        p2s_par_en <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    p2s_par_en <= 1'b0;
                end
            endcase

            if (p2s_par_en && (r_cnt == '0)) begin
                burst_id <= r_cur_id;
            end

            if (w_seq_end != r_exp_last) begin
                frame_err <= 1'b1;
            end

            if (w_seq_end) begin
                burst_done_cnt <= burst_done_cnt + 16'd1;
            end

            // One beat is owed per load cycle; a beat with nothing owed is ignored.
            if (p2s_par_en && !(p2s_seq_valid && (r_out != '0))) begin
                if (r_out != '1) begin
                    r_out <= r_out + 1'b1;
                end
            end else if (!p2s_par_en && p2s_seq_valid && (r_out != '0)) begin
                r_out <= r_out - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fm_add_p2s_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fm_add_p2s_arb
// Brief    : Self-checking bench for fm_add_p2s_arb: vector table, directed
//            multi-cycle sequences and random traffic against a burst model.
// Revision : 1.0
// ============================================================================
module tb_fm_add_p2s_arb;

    localparam int NUM_REQ = 4;
    localparam int SEQ_CNT = 5;
    localparam int ADW     = 16;
    localparam int IDW     = 2;
    localparam int WW      = SEQ_CNT * ADW;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WW-1:0]    par_in;
    logic [NUM_REQ-1:0]       ack;
    logic                     dst_ready;
    logic                     p2s_par_en;
    logic [WW-1:0]            p2s_par;
    logic                     p2s_seq_valid;
    logic                     p2s_seq_last;
    logic [IDW-1:0]           burst_id;
    logic                     busy;
    logic [15:0]              burst_done_cnt;
    logic                     frame_err;

    always #5 clk = ~clk;

    fm_add_p2s_arb #(
        .NUM_REQ        (NUM_REQ),
        .SEQ_CNT        (SEQ_CNT),
        .APP_DATA_WIDTH (ADW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .par_in         (par_in),
        .ack            (ack),
        .dst_ready      (dst_ready),
        .p2s_par_en     (p2s_par_en),
        .p2s_par        (p2s_par),
        .p2s_seq_valid  (p2s_seq_valid),
        .p2s_seq_last   (p2s_seq_last),
        .burst_id       (burst_id),
        .busy           (busy),
        .burst_done_cnt (burst_done_cnt),
        .frame_err      (frame_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Serializer stand-in: one beat per load cycle, last on beat index last_idx.
    bit ser_auto;
    int ser_beat;
    int inj_idx;

    logic [WW-1:0] sl [NUM_REQ];

    // Burst-level reference model state.
    int                 m_pos;
    int                 m_rr;
    int                 m_cur;
    logic [WW-1:0]      m_hold;
    logic [IDW-1:0]     m_bid;
    logic               m_busy;
    logic [15:0]        m_done;
    logic [NUM_REQ-1:0] m_ack;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic               dr;
        logic [NUM_REQ-1:0] ack;
        logic               pe;
        logic [IDW-1:0]     bid;
        logic               busy;
        logic [15:0]        done;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[WW-1:0];
    endfunction

    task automatic set_slice(input int i, input logic [WW-1:0] v);
        sl[i] = v;
        par_in[i*WW +: WW] = v;
    endtask

    task automatic tick();
        logic pe;
        int   last_idx;
        pe = p2s_par_en;
        last_idx = (inj_idx >= 0) ? inj_idx : SEQ_CNT - 1;
        @(posedge clk);
        #1;
        cyc++;
        if (ser_auto) begin
            p2s_seq_valid = pe;
            p2s_seq_last  = pe && (ser_beat == last_idx);
            if (pe) ser_beat = (ser_beat == SEQ_CNT - 1) ? 0 : ser_beat + 1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        dst_ready = 1'b0;
        ser_auto  = 1'b1;
        inj_idx   = -1;
        tick();
        tick();
        ser_beat      = 0;
        p2s_seq_valid = 1'b0;
        p2s_seq_last  = 1'b0;
        rst           = 1'b1;
        cyc           = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},   ack, 0);
        chk({tag, "_paren"}, p2s_par_en, 0);
        chk({tag, "_par"},   p2s_par, 0);
        chk({tag, "_bid"},   burst_id, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_cnt"},   burst_done_cnt, 0);
        chk({tag, "_ferr"},  frame_err, 0);
    endtask

    task automatic model_step();
        int np;
        int g;
        logic [NUM_REQ-1:0] na;
        na = '0;
        g  = -1;
        if (m_pos == 0) m_bid = IDW'(m_cur);
        if ((m_pos < 0 || m_pos == SEQ_CNT - 1) && dst_ready) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && req[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
            end
        end
        if (g >= 0) begin
            np     = 0;
            m_hold = sl[g];
            m_rr   = (g + 1) % NUM_REQ;
            na[g]  = 1'b1;
            m_cur  = g;
        end else if (m_pos >= 0 && m_pos < SEQ_CNT - 1) begin
            np = m_pos + 1;
        end else begin
            np = -1;
        end
        m_busy = (np >= 0) || (m_pos >= 0);
        if (p2s_seq_valid && p2s_seq_last) m_done = m_done + 16'd1;
        m_pos = np;
        m_ack = na;
    endtask

    initial begin
        int gaps;
        logic [NUM_REQ-1:0] e;
        logic [NUM_REQ-1:0] ack_seen;

        rst = 1'b0; req = '0; dst_ready = 1'b0;
        p2s_seq_valid = 1'b0; p2s_seq_last = 1'b0;
        par_in = '0; ser_auto = 1'b1; ser_beat = 0; inj_idx = -1;
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, rnd_word());

        // Reset values
        do_reset();
        @(negedge clk);
        chk_reset_vals("rst");

        // Single request on requester 2, cycle-by-cycle table
        tbl[0] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'd0};
        tbl[1] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1, 16'd0};
        tbl[2] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 16'd0};
        tbl[3] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 16'd0};
        tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 16'd0};
        tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 16'd0};
        tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 16'd0};
        tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd1};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 16'd1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req       = tbl[i].req;
            dst_ready = tbl[i].dr;
            @(negedge clk);
            chk("t1_ack",   ack, tbl[i].ack);
            chk("t1_paren", p2s_par_en, tbl[i].pe);
            chk("t1_bid",   burst_id, tbl[i].bid);
            chk("t1_busy",  busy, tbl[i].busy);
            chk("t1_cnt",   burst_done_cnt, tbl[i].done);
            if (tbl[i].pe) chk("t1_par", p2s_par, sl[2]);
            tick();
        end
        chk("t1_ferr", frame_err, 0);

        // All requesters held high: grants 0,1,2,3,0 with no load gap
        do_reset();
        req = 4'hF; dst_ready = 1'b1; gaps = 0;
        for (int c = 0; c <= 25; c++) begin
            e = '0;
            if (c >= 1 && ((c - 1) % 5) == 0) e = NUM_REQ'(1) << (((c - 1) / 5) % NUM_REQ);
            @(negedge clk);
            chk("t2_ack", ack, e);
            if (c >= 1 && !p2s_par_en) gaps++;
            if (c == 7)  chk("t2_bid7", burst_id, 1);
            if (c == 12) chk("t2_bid12", burst_id, 2);
            tick();
        end
        chk("t2_gaps", gaps, 0);
        chk("t2_ferr", frame_err, 0);

        // dst_ready low blocks the grant
        do_reset();
        req = 4'b0010; dst_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_noack", ack, 0);
            chk("t3_idle", busy, 0);
            tick();
        end
        dst_ready = 1'b1;
        @(negedge clk);
        chk("t3_ack10", ack, 0);
        tick();
        @(negedge clk);
        chk("t3_ack11", ack, 4'b0010);
        tick();
        req = '0;
        repeat (8) tick();

        // Reset in the third load cycle of a burst
        do_reset();
        req = 4'b1010; dst_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_ack1", ack, 4'b0010);
        tick();
        req = 4'b1000;
        tick();
        @(negedge clk);
        chk("t4_paren3", p2s_par_en, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1; req = 4'b1010; ser_beat = 0;
        @(negedge clk);
        chk_reset_vals("t4_rst");
        tick();
        @(negedge clk);
        chk("t4_ack5", ack, 4'b0010);
        tick();
        req = 4'b1000;
        for (int c = 6; c <= 10; c++) begin
            if (c > 6) tick();
            @(negedge clk);
            if (c == 10) chk("t4_ack10", ack, 4'b1000);
        end
        tick();
        req = '0;
        repeat (8) tick();
        chk("t4_ferr", frame_err, 0);

        // Early last on beat 2 -> sticky framing error
        do_reset();
        inj_idx = 2; req = 4'b0001; dst_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4)  chk("t5_ferr4", frame_err, 0);
            if (c == 5)  chk("t5_ferr5", frame_err, 1);
            if (c == 12) chk("t5_ferr12", frame_err, 1);
            tick();
            if (c == 1) req = '0;
        end
        do_reset();
        @(negedge clk);
        chk("t5_ferr_clr", frame_err, 0);

        // Done counter wrap: 65535 raw last beats, then one real burst
        ser_auto = 1'b0;
        p2s_seq_valid = 1'b1; p2s_seq_last = 1'b1;
        repeat (65535) tick();
        p2s_seq_valid = 1'b0; p2s_seq_last = 1'b0;
        @(negedge clk);
        chk("t6_cnt_max", burst_done_cnt, 16'hFFFF);
        ser_auto = 1'b1; ser_beat = 0;
        req = 4'b0001; dst_ready = 1'b1;
        tick();
        tick();
        req = '0;
        repeat (6) tick();
        @(negedge clk);
        chk("t6_cnt_wrap", burst_done_cnt, 0);

        // Random traffic against the reference model
        do_reset();
        m_pos = -1; m_rr = 0; m_cur = 0; m_hold = '0; m_bid = '0;
        m_busy = 1'b0; m_done = '0; m_ack = '0; ack_seen = '0;
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_seen[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    set_slice(i, rnd_word());
                    req[i] = 1'b1;
                end
            end
            dst_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            chk("rnd_ack",   ack, m_ack);
            chk("rnd_paren", p2s_par_en, (m_pos >= 0));
            chk("rnd_par",   p2s_par, m_hold);
            chk("rnd_bid",   burst_id, m_bid);
            chk("rnd_busy",  busy, m_busy);
            chk("rnd_cnt",   burst_done_cnt, m_done);
            chk("rnd_ferr",  frame_err, 0);
            ack_seen = ack;
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fm_add_p2s_arb.md
Name: fm_add_p2s_arb

Overview:
- Round-robin arbiter and sequencer that shares one parallel-to-serial serializer among NUM_REQ feature-map-add requesters.
- Captures the granted requester's SEQ_CNT-beat parallel word and drives the serializer load interface.
- Tags the outgoing beat stream with the source ID and checks the serializer's burst framing.
- Sits between the fm-add units and the serializer feeding the DDR write path.

Parameters:
- NUM_REQ, 4, number of requesters (2..16); IDW = max(1, clog2(NUM_REQ)).
- SEQ_CNT, 5, beats per burst (2..63); matches the serializer.
- APP_DATA_WIDTH, 64, beat width in bits.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-low.
- req  in  NUM_REQ  per-requester request level; held until ack.
- par_in  in  NUM_REQ*SEQ_CNT*APP_DATA_WIDTH  requester i word at slice i.
- ack  out  NUM_REQ  one-hot, one-cycle capture pulse.
- dst_ready  in  1  downstream can accept a whole burst.
- p2s_par_en  out  1  serializer load enable.
- p2s_par  out  SEQ_CNT*APP_DATA_WIDTH  word to serializer.
- p2s_seq_valid  in  1  serializer beat valid.
- p2s_seq_last  in  1  serializer last-beat flag.
- burst_id  out  IDW  source of the beats currently leaving the serializer.
- busy  out  1  a burst is being loaded or is in flight.
- burst_done_cnt  out  16  completed bursts; wraps at 0xFFFF to 0.
- frame_err  out  1  sticky framing error.

Behaviour:
- Reset values (rst==0 at a clock edge): ack=0, p2s_par_en=0, p2s_par=0, burst_id=0, busy=0, burst_done_cnt=0, frame_err=0. Hold counter=0, RR pointer=0, FSM=IDLE.
- Reset mid-burst: p2s_par_en drops the next cycle. An un-acked request stays pending and is re-arbitrated after reset.
- Serializer contract:
  - p2s_par_en is held high for exactly SEQ_CNT consecutive cycles per burst.
  - p2s_par is constant over that window.
  - Beats appear on the cycles after each par_en cycle.
- FSM has two states, IDLE and LOAD.
- IDLE:
  - If (req != 0) and dst_ready in cycle c, grant the first set req at or after the RR pointer (wrapping).
  - At the edge ending c: capture par_in slice into the hold register and set RR pointer = grant+1 mod NUM_REQ.
  - In cycle c+1: ack[grant]=1; FSM enters LOAD.
- LOAD:
  - p2s_par_en=1 and hold counter counts 0..SEQ_CNT-1.
  - On the cycle with counter==SEQ_CNT-1, arbitrate again. If a winner exists and dst_ready=1, reload, pulse its ack next cycle and stay in LOAD with counter=0, so p2s_par_en has no gap.
  - Otherwise return to IDLE (p2s_par_en=0 next cycle).
- A requester is never acked twice for one capture. req dropped before ack is a protocol violation; the arbiter must still not hang.
- dst_ready is sampled only at grant; its deassertion mid-burst does not stall a burst.
- burst_id: updated to the granted ID one cycle after each p2s_par_en rising or reload cycle, i.e. aligned with the first beat of that burst.
- busy = FSM==LOAD or any expected beat not yet seen.
- Framing check:
  - Expected-last = p2s_par_en was high with counter==SEQ_CNT-1 in the previous cycle.
  - frame_err sets if p2s_seq_valid&p2s_seq_last differs from expected-last.
  - Cleared only by reset.
- burst_done_cnt increments on each p2s_seq_valid&p2s_seq_last.

Test Plan:
- Single request: req[2]=1 with dst_ready=1 in cycle 0 -> ack[2] in cycle 1; p2s_par_en cycles 1..5 with p2s_par = slice 2; burst_id=2 from cycle 2; burst_done_cnt=1; frame_err=0.
- All four req high continuously -> grants in order 0,1,2,3,0, back-to-back with p2s_par_en never low between bursts; acks 5 cycles apart.
- dst_ready=0 with req[1]=1 for 10 cycles, then 1 -> no ack before dst_ready rises; ack[1] one cycle after.
- rst=0 at the third cycle of a burst -> all outputs at reset values the next cycle; a pending req[3] is re-granted after release; RR restarts at 0.
- Inject p2s_seq_last at cnt 2 via a serializer model -> frame_err=1 and stays 1 until reset.
- Force burst_done_cnt to 0xFFFF then one burst -> burst_done_cnt=0.
